// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundles the hazard-detection inputs and pipeline-register control outputs
// exchanged between the 5-stage pipeline datapath and its stall/flush controller.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_memread;
  logic        ex_branch_taken;
  // mem_req/mem_ready: MEM holds an access while mem_req=1; the access
  // completes in the cycle mem_ready=1, and until then the pipeline is frozen.
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_write;
  logic        ex_mem_write;
  logic        id_ex_bubble;
  logic        if_id_flush;
  logic [1:0]  stall_state;
  logic        mem_timeout;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memread,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
           if_id_flush, stall_state, mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memread,
           ex_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
           if_id_flush, stall_state, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: combinational pipeline-register enables plus
// a diagnostic stall-state register, memory-wait timeout and saturating counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOAD_USE = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q;
  logic        timeout_q;
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  logic mem_wait, load_use, flush_go;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble, if_id_flush;

  assign mem_wait = hz.mem_req & ~hz.mem_ready;
  assign load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
  // A branch seen during a memory wait is deferred until the access completes.
  assign flush_go = hz.ex_branch_taken & ~mem_wait;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (reset) begin
      pc_write = 1'b1;
    end else if (mem_wait) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (hz.ex_branch_taken) begin
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    if (mem_wait)
      state_d = ST_MEM_WAIT;
    else if (load_use && !hz.ex_branch_taken)
      state_d = ST_LOAD_USE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 16'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (mem_wait) begin
        if (wait_cnt_q != 16'hFFFF)
          wait_cnt_q <= wait_cnt_q + 16'd1;
        if (wait_cnt_q == TIMEOUT_M1)
          timeout_q <= 1'b1;
      end else begin
        wait_cnt_q <= 16'd0;
      end
      if (!pc_write && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_go && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.id_ex_write  = id_ex_write;
  assign hz.ex_mem_write = ex_mem_write;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.stall_state  = state_q;
  assign hz.mem_timeout  = timeout_q;
  assign hz.stall_cycles = stall_cnt_q;
  assign hz.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios, randomized traffic and a
// long saturation run, all compared against a rule-level reference model.
module tb_pipeline_hazard_ctrl;
  localparam int TB_TIMEOUT = 4;
  localparam int SAT = 65535;

  logic clk;
  logic reset;
  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [5:0] exp_q[$];

  // reference model state (values visible on the registered outputs)
  bit m_known = 0;
  int m_state = 0;
  bit m_timeout = 0;
  int m_wait = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit f_load_use();
    return hz.ex_memread && (hz.ex_rd != 0) &&
           ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) ||
            (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));
  endfunction

  // {pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble, if_id_flush}
  function automatic logic [5:0] f_ctrl();
    bit mw;
    mw = hz.mem_req && !hz.mem_ready;
    if (reset)                   return 6'b111100;
    else if (mw)                 return 6'b000000;
    else if (hz.ex_branch_taken) return 6'b111111;
    else if (f_load_use())       return 6'b001110;
    else                         return 6'b111100;
  endfunction

  task automatic model_update();
    bit mw, lu;
    logic [5:0] c;
    mw = hz.mem_req && !hz.mem_ready;
    lu = f_load_use();
    c  = f_ctrl();
    if (reset) begin
      m_known = 1; m_state = 0; m_timeout = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_state = mw ? 2 : ((lu && !hz.ex_branch_taken) ? 1 : 0);
      if (mw) begin
        if (m_wait < SAT) m_wait++;
        if (m_wait == TB_TIMEOUT) m_timeout = 1;
      end else begin
        m_wait = 0;
      end
      if (!c[5] && m_stall < SAT) m_stall++;
      if (hz.ex_branch_taken && !mw && m_flush < SAT) m_flush++;
    end
  endtask

  // driver: apply one cycle of inputs, check, then advance the model
  task automatic apply(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic req, input logic rdy);
    logic [5:0] got, exp;
    @(negedge clk);
    reset = rst;
    hz.id_rs1 = rs1; hz.id_rs2 = rs2; hz.id_uses_rs1 = u1; hz.id_uses_rs2 = u2;
    hz.ex_rd = rd; hz.ex_memread = mr; hz.ex_branch_taken = br;
    hz.mem_req = req; hz.mem_ready = rdy;
    #1;
    exp_q.push_back(f_ctrl());
    got = {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write,
           hz.id_ex_bubble, hz.if_id_flush};
    exp = exp_q.pop_front();
    check_eq("ctrl", 32'(got), 32'(exp));
    if (m_known) begin
      check_eq("stall_state", 32'(hz.stall_state), 32'(m_state));
      check_eq("mem_timeout", 32'(hz.mem_timeout), 32'(m_timeout));
      check_eq("stall_cycles", 32'(hz.stall_cycles), 32'(m_stall));
      check_eq("flush_count", 32'(hz.flush_count), 32'(m_flush));
    end
    model_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_uses_rs1 = 0; hz.id_uses_rs2 = 0;
    hz.ex_rd = 0; hz.ex_memread = 0; hz.ex_branch_taken = 0;
    hz.mem_req = 0; hz.mem_ready = 0;

    do_reset();
    idle(2);

    // load-use on rs2, then the bubble clears it
    apply(0, 1, 5, 1, 1, 5, 1, 0, 0, 0);
    idle(2);
    check_eq("lu_stall_cycles", 32'(hz.stall_cycles), 32'd1);

    // x0 and unused-operand filters
    apply(0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    apply(0, 7, 3, 0, 1, 7, 1, 0, 0, 0);
    idle(1);

    // branch wins over a load-use match
    apply(0, 9, 0, 1, 0, 9, 1, 1, 0, 0);
    idle(2);
    check_eq("br_flush_count", 32'(hz.flush_count), 32'd1);
    check_eq("br_stall_cycles", 32'(hz.stall_cycles), 32'd1);

    // 3-cycle memory wait, branch deferred across it
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(2);
    check_eq("mw_stall_cycles", 32'(hz.stall_cycles), 32'd4);
    check_eq("mw_flush_count", 32'(hz.flush_count), 32'd2);
    check_eq("mw_timeout", 32'(hz.mem_timeout), 32'd0);

    // timeout after TB_TIMEOUT wait cycles, sticky until reset
    for (int i = 0; i < 6; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3);
    check_eq("to_sticky", 32'(hz.mem_timeout), 32'd1);
    do_reset();
    idle(1);
    check_eq("to_cleared", 32'(hz.mem_timeout), 32'd0);
    check_eq("rst_stall_cycles", 32'(hz.stall_cycles), 32'd0);

    // reset in the middle of a wait
    for (int i = 0; i < 5; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    do_reset();
    idle(2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic rst_r, br_r, req_r, rdy_r;
      rst_r = ($urandom_range(0, 199) == 0);
      br_r  = ($urandom_range(0, 5) == 0);
      req_r = ($urandom_range(0, 2) == 0);
      rdy_r = ($urandom_range(0, 3) != 0);
      apply(rst_r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            br_r, req_r, rdy_r);
    end

    // stall counter saturation
    do_reset();
    for (int i = 0; i < 70000; i++) apply(0, 4, 0, 1, 0, 4, 1, 0, 0, 0);
    idle(1);
    check_eq("sat_stall_cycles", 32'(hz.stall_cycles), 32'hFFFF);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Inputs: decoded source registers from the IF/ID stage, destination/MemRead fields from the ID/EX register outputs, branch resolution from EX, and the data-memory handshake from MEM.
- Outputs: the write enables and bubble/flush selects that drive the PC, IF/ID, ID/EX and EX/MEM registers.
- Internal state: a memory-wait state machine with timeout detection, plus saturating performance counters.

## Interface
Parameters:
- TIMEOUT, 255: MEM_WAIT cycles before mem_timeout is raised (1..65535).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_rs1  in  5  rs1 field of instruction in ID
- id_rs2  in  5  rs2 field of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  RD from ID/EX register output
- ex_memread  in  1  MemRead from ID/EX register output
- ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle
- mem_req  in  1  MEM stage holds a load or store
- mem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID write enable
- id_ex_write  out  1  ID/EX write enable (drives its write input)
- ex_mem_write  out  1  EX/MEM write enable
- id_ex_bubble  out  1  select all-zero control fields into ID/EX
- if_id_flush  out  1  clear IF/ID (insert NOP)
- stall_state  out  2  0 RUN, 1 LOAD_USE, 2 MEM_WAIT
- mem_timeout  out  1  sticky: MEM_WAIT lasted TIMEOUT cycles
- stall_cycles  out  16  saturating count of cycles with pc_write=0
- flush_count  out  16  saturating count of branch flushes

## Operation
Definitions:
- mem_wait = mem_req & ~mem_ready
- load_use = ex_memread & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))

Per-cycle control, priority high to low:
- reset: all four write enables 1; bubble 0, flush 0.
- mem_wait: full freeze. pc_write = if_id_write = id_ex_write = ex_mem_write = 0; bubble 0, flush 0.
- ex_branch_taken: all write enables 1; if_id_flush = 1, id_ex_bubble = 1. A simultaneous load_use is ignored because its instruction is flushed.
- load_use: pc_write = 0, if_id_write = 0; id_ex_write = 1, ex_mem_write = 1; id_ex_bubble = 1; flush 0.
- otherwise: all write enables 1; bubble 0, flush 0.

State machine (stall_state register), next state evaluated each cycle in all states:
- mem_wait → MEM_WAIT
- else load_use & ~ex_branch_taken → LOAD_USE
- else → RUN
- stall_state reports the condition applied in the previous cycle (diagnostic only). Outputs never depend on it.

Wait counter (internal, 16-bit):
- Increments each cycle that mem_wait = 1; cleared to 0 on any cycle with mem_wait = 0.
- mem_timeout is set when the counter equals TIMEOUT-1 while mem_wait = 1, i.e. on the edge ending the TIMEOUT-th consecutive wait cycle.
- mem_timeout stays set until reset. The freeze continues; the controller never aborts an access.
- The counter saturates at 0xFFFF.

Performance counters:
- stall_cycles: +1 on every non-reset cycle with pc_write = 0 (load-use and mem-wait).
- flush_count: +1 on every non-reset cycle where the branch flush is applied (ex_branch_taken & ~mem_wait).
- Both saturate at 0xFFFF and never wrap.

## Timing
- All control outputs are combinational from current inputs; zero-cycle latency. They are valid within the same cycle in which the pipeline registers sample on the next edge.
- stall_state, mem_timeout, stall_cycles, flush_count: registered, updated one edge after the causing cycle.
- Reset values: stall_state = 0, mem_timeout = 0, stall_cycles = 0, flush_count = 0, wait counter = 0.
- A load-use stall lasts exactly one cycle: on the next cycle ex_memread comes from the bubble (0), so load_use deasserts.
- If mem_wait and ex_branch_taken coincide, the flush is deferred. ex_branch_taken must persist because ID/EX is frozen. The flush is applied and counted once, in the first cycle mem_ready = 1.
- Reset mid-MEM_WAIT: at the next edge all state is cleared and mem_timeout is cleared.

## Test plan
- Load-use: ex_memread = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1 → pc_write = 0, if_id_write = 0, id_ex_bubble = 1 for one cycle; stall_state = 1 next cycle; stall_cycles = 1.
- x0 and unused-operand filter: ex_rd = 0 with id_rs1 = 0; and ex_rd = 7, id_rs1 = 7, id_uses_rs1 = 0 → no stall; all write enables 1.
- Branch vs load-use: ex_branch_taken = 1 together with a load_use match → if_id_flush = 1, id_ex_bubble = 1, pc_write = 1; flush_count = 1; stall_cycles unchanged.
- Memory wait: mem_req = 1, mem_ready = 0 for 3 cycles, then mem_ready = 1 → all enables 0 for 3 cycles, then 1; stall_state = 2 during the wait; stall_cycles = 3; mem_timeout = 0.
- Timeout: TIMEOUT = 4, mem_wait held 6 cycles → mem_timeout rises after the 4th wait cycle, the freeze persists, mem_timeout stays 1 after mem_ready; a reset pulse clears it and all counters to 0.
- Saturation: 70000 consecutive load-use cycles → stall_cycles holds 0xFFFF and does not wrap to 0.
